// File: rtl/rtc_write_seq.sv
// rtc_write_seq
// Commits a set of BCD time/date fields into an RTC through a simple
// request/acknowledge serial write engine. A commit clears write protect,
// writes every selected field in ascending index order, and (optionally)
// sets write protect again.
//
// Optional feature macro: RTC_WP_RELOCK_EN
//   defined   -> a final write (WP_ADDR, 8'h80) re-arms write protect
//   undefined -> the sequence ends after the last field, protect left cleared
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle commit request, ignored while busy
//   fieldMask  bit i selects field i for writing
//   fieldData  field i in bits [8i+7:8i]
//   writeDone  serial engine acknowledge for the current request
//   writeEn    write request level, held until acknowledged
//   writeAddr  register address of the current request
//   writeData  register data of the current request
//   busy       high from accepted start until the sequence ends
//   done       one-cycle pulse on successful completion
//   err        one-cycle pulse when a request times out
//   curField   field index being written, NUM_FIELDS otherwise
module rtc_write_seq #(
  parameter int         NUM_FIELDS  = 7,
  parameter logic [7:0] BASE_ADDR   = 8'h80,
  parameter logic [7:0] WP_ADDR     = 8'h8E,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_FIELDS-1:0]           fieldMask,
  input  logic [8*NUM_FIELDS-1:0]         fieldData,
  input  logic                            writeDone,
  output logic                            writeEn,
  output logic [7:0]                      writeAddr,
  output logic [7:0]                      writeData,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [$clog2(NUM_FIELDS+1)-1:0] curField
);

  localparam int IW = $clog2(NUM_FIELDS + 1);
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] T_LAST   = CW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] IDX_NONE = IW'(NUM_FIELDS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNLOCK = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_FIELD  = 3'd3;
  localparam logic [2:0] S_RELOCK = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]              state;
  logic [IW-1:0]           scanIdx;
  logic [NUM_FIELDS-1:0]   maskSnap;
  logic [8*NUM_FIELDS-1:0] dataSnap;
  logic [CW-1:0]           toCnt;

  // Sequencer. Every request is launched on the edge that enters its state
  // (UNLOCK, FIELD, RELOCK), so writeEn is high for the whole time the FSM
  // sits in one of those states and address/data never move in between.
  // Each request is always followed by a SCAN or FINISH cycle, which gives
  // the mandatory idle cycle between back-to-back writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      scanIdx   <= '0;
      maskSnap  <= '0;
      dataSnap  <= '0;
      toCnt     <= '0;
      writeEn   <= 1'b0;
      writeAddr <= 8'h00;
      writeData <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      curField  <= IDX_NONE;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            maskSnap <= fieldMask;
            dataSnap <= fieldData;
            scanIdx  <= '0;
            busy     <= 1'b1;
            if (fieldMask == '0) begin
              state <= S_FINISH;
            end else begin
              state     <= S_UNLOCK;
              writeEn   <= 1'b1;
              writeAddr <= WP_ADDR;
              writeData <= 8'h00;
              toCnt     <= '0;
            end
          end
        end

        // The three request states share acknowledge and timeout handling;
        // only the follow-on state differs.
        S_UNLOCK, S_FIELD, S_RELOCK: begin
          if (writeDone) begin
            writeEn  <= 1'b0;
            curField <= IDX_NONE;
            if (state == S_FIELD) begin
              scanIdx <= scanIdx + IW'(1);
              state   <= S_SCAN;
            end else if (state == S_UNLOCK) begin
              state <= S_SCAN;
            end else begin
              state <= S_FINISH;
            end
          end else if (toCnt == T_LAST) begin
            // Abort: write protect is deliberately not restored because the
            // engine is evidently not responding.
            writeEn  <= 1'b0;
            err      <= 1'b1;
            busy     <= 1'b0;
            curField <= IDX_NONE;
            state    <= S_IDLE;
          end else begin
            toCnt <= toCnt + CW'(1);
          end
        end

        S_SCAN: begin
          if (scanIdx >= IDX_NONE) begin
`ifdef RTC_WP_RELOCK_EN
            state     <= S_RELOCK;
            writeEn   <= 1'b1;
            writeAddr <= WP_ADDR;
            writeData <= 8'h80;
            toCnt     <= '0;
`else
            state <= S_FINISH;
`endif
          end else if (maskSnap[scanIdx]) begin
            state     <= S_FIELD;
            writeEn   <= 1'b1;
            writeAddr <= 8'(BASE_ADDR + 2 * scanIdx);
            writeData <= dataSnap[8*scanIdx +: 8];
            curField  <= scanIdx;
            toCnt     <= '0;
          end else begin
            scanIdx <= scanIdx + IW'(1);
          end
        end

        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rtc_write_seq.md
RTC_WRITE_SEQ -- requirements
Module: rtc_write_seq

Interface
REQ-001 Parameter NUM_FIELDS, default 7; number of RTC data registers, with field i at index 0..NUM_FIELDS-1 (0=sec … 6=yr).
REQ-002 Parameter BASE_ADDR, default 8'h80; write address of field i is BASE_ADDR + 2*i (8-bit).
REQ-003 Parameter WP_ADDR, default 8'h8E; write-protect register address.
REQ-004 Parameter TIMEOUT_CYC, default 1000000; maximum cycles to wait for writeDone per write.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle commit request.
REQ-008 fieldMask  input  NUM_FIELDS  bit i=1 means field i is written.
REQ-009 fieldData  input  8*NUM_FIELDS  field i occupies bits [8i+7:8i], BCD as delivered.
REQ-010 writeDone  input  1  serial engine acknowledges completion of the current write.
REQ-011 writeEn  output  1  write request, level, held until acknowledged.
REQ-012 writeAddr  output  8  register address of the current request.
REQ-013 writeData  output  8  register data of the current request.
REQ-014 busy  output  1  high from accepted start until sequence end.
REQ-015 done  output  1  one-cycle pulse on successful completion.
REQ-016 err  output  1  one-cycle pulse on timeout abort.
REQ-017 curField  output  $clog2(NUM_FIELDS+1)  index of the field being written; NUM_FIELDS during WP writes or idle.

Function
REQ-018 States: IDLE, UNLOCK, SCAN, FIELD, RELOCK, FINISH.
REQ-019 In IDLE, start=1 latches fieldMask/fieldData into snapshot registers, sets busy next cycle, and transitions to UNLOCK; if the latched mask is zero, it transitions to FINISH instead.
REQ-020 start while busy is ignored, and the snapshot is not altered.
REQ-021 UNLOCK drives writeEn=1, writeAddr=WP_ADDR, writeData=8'h00.
REQ-022 A request completes on the first clock edge where writeEn=1 and writeDone=1; writeEn deasserts the next cycle.
REQ-023 writeDone while writeEn=0 is ignored.
REQ-024 Consecutive requests are separated by at least one writeEn=0 cycle.
REQ-025 SCAN examines one field index per cycle, starting at 0: mask bit set → FIELD; clear → index+1; index past NUM_FIELDS-1 → RELOCK (or FINISH, see REQ-034).
REQ-026 FIELD drives writeEn=1, writeAddr=BASE_ADDR+2*i, writeData=snapshot byte i, and returns to SCAN at index i+1 on completion.
REQ-027 writeAddr and writeData remain stable for the whole writeEn-high interval.
REQ-028 Timeout counter clears at each request start and increments each cycle writeEn=1 without writeDone.
REQ-029 On reaching TIMEOUT_CYC-1, writeEn drops, err pulses, busy clears, state returns to IDLE, and no relock is attempted.
REQ-030 FINISH pulses done for one cycle, clears busy, and returns to IDLE; done and err are never high together.
REQ-031 writeEn is 0 whenever busy is 0.

Reset
REQ-032 rst=0 immediately forces IDLE, and writeEn=0, writeAddr=8'h00, writeData=8'h00, busy=0, done=0, err=0, curField=NUM_FIELDS, timeout counter=0, snapshot=0.
REQ-033 Reset asserted mid-sequence abandons the sequence without done/err; the first start after release begins a full new sequence.

Configuration
REQ-034 Macro RTC_WP_RELOCK_EN defined: RELOCK state issues writeAddr=WP_ADDR, writeData=8'h80 after the last field, then FINISH. Undefined: SCAN end goes directly to FINISH, and write protect is left cleared.

Verification
REQ-035 Mask 7'b1000000, yr=8'h24, writeDone pulsed 50 cycles after each writeEn rise -> writes (8E,00), (8C,24), (8E,80) with macro defined; done pulse; busy low after.
REQ-036 Mask 7'b0000110, min=8'h30, hrs=8'h12 -> writes (8E,00), (82,30), (84,12), then relock; curField shows 1 then 2.
REQ-037 Mask 0 -> no writeEn; done pulses 2 cycles after start.
REQ-038 TIMEOUT_CYC=100, writeDone never asserted -> writeEn high exactly 100 cycles, err pulse, no relock write, busy=0.
REQ-039 Second start during field write with different data -> ignored; written bytes match the first snapshot.
REQ-040 rst=0 while writeEn high during field write -> writeEn=0 asynchronously; after release, start yields a sequence beginning with (8E,00).
